multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle MIPS control unit; successor to the single-cycle combinational decoder.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states over a shared memory and ALU.
//  Adds a memory-ready stall handshake, an illegal-opcode flag and a per-instruction done pulse.
//  Sits between the instruction register opcode field and the multi-cycle datapath mux/enable controls.
// PARAMETERS
//  OPCODE_W   6   opcode field width
//  ALUOP_W    3   ALUOp width (>=3)
//  USE_READY  1   1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         synchronous, active-high
//  opcode     in   OPCODE_W  IR[31:26], sampled in DECODE
//  zero       in   1         ALU zero flag, used in BRANCH
//  mem_ready  in   1         memory access complete this cycle
//  PCWrite    out  1         unconditional PC load
//  PCWriteCond out 1         PC load if zero (beq)
//  IorD       out  1         0: mem addr=PC, 1: mem addr=ALUOut
//  MemRead    out  1         memory read strobe
//  MemWrite   out  1         memory write strobe
//  IRWrite    out  1         instruction register load
//  MemToReg   out  1         1: write-back data from MDR
//  RegDst     out  1         1: rd, 0: rt
//  RegWrite   out  1         register file write enable
//  ALUSrcA    out  1         0: PC, 1: rs
//  ALUSrcB    out  2         00 rt, 01 const 4, 10 signext imm, 11 imm<<2
//  ALUOp      out  ALUOP_W   000 add, 001 sub, 010 funct, 011 or, 100 and, 101 slt
//  PCSource   out  2         00 ALU, 01 ALUOut, 10 jump target
//  instr_done out  1         1-cycle pulse in an instruction's final state
//  illegal_op out  1         1-cycle pulse in DECODE on unsupported opcode
// BEHAVIOUR
//  - Moore FSM; outputs decoded from state register only (except stall gating below).
//  - reset=1 at a clock edge: state<=FETCH. While reset is high, every output is forced 0.
//    Reset mid-instruction abandons it; no partial write is completed.
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00.
//    IRWrite=PCWrite=mem_ready. Advance to DECODE when mem_ready, else hold.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target). Next by opcode:
//    000000->EXEC_R; 001000/001101/001100/001010 (addi/ori/andi/slti)->EXEC_I;
//    100011/101011 (lw/sw)->MEMADR; 000100->BRANCH; 000010->JUMP;
//    other->FETCH with illegal_op=1, instr_done=0.
//  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=funct -> RTYPE_WB (RegDst=1, RegWrite=1, MemToReg=0).
//  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp add/or/and/slt per opcode -> ITYPE_WB (RegDst=0, RegWrite=1).
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=add -> MEMRD (lw) or MEMWR (sw).
//  - MEMRD: MemRead=1, IorD=1; hold until mem_ready -> MEM_WB (RegDst=0, MemToReg=1, RegWrite=1).
//  - MEMWR: MemWrite=1, IorD=1; hold until mem_ready; final state.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01; final state.
//  - JUMP: PCWrite=1, PCSource=10; final state.
//  - Final states (RTYPE_WB, ITYPE_WB, MEM_WB, MEMWR when ready, BRANCH, JUMP) assert
//    instr_done and return to FETCH.
//  - Latency at mem_ready=1: beq/j 3, R/I-type/sw 4, lw 5 cycles. Each stall cycle adds 1.
//  - Stall: MemRead/MemWrite stay high and IorD stable for all stall cycles; no PC/IR/RF update.
//  - Unused state encodings recover to FETCH on the next edge.
// TESTING
//  - reset high 2 cycles, then low, mem_ready=1 -> all outputs 0 during reset; FETCH next
//    with MemRead=1, IRWrite=1, PCWrite=1.
//  - opcode 000000, 001000, 100011, 101011, 000100, 000010 back to back -> instr_done after
//    4,4,5,4,3,3 cycles; RegWrite only in R/I/lw write-back; MemWrite=1 only for 101011.
//  - opcode 100011, mem_ready low 3 cycles in FETCH and 2 in MEMRD -> lw completes in 10 cycles;
//    IRWrite pulses once; MemRead continuously high during stalls.
//  - opcode 000100 with zero=1 then zero=0 -> PCWriteCond=1, ALUOp=001 in BRANCH both times.
//  - opcode 111111 -> illegal_op pulse in DECODE, no RegWrite/MemWrite, FETCH next cycle.
//  - reset asserted during MEMWR with mem_ready=0 -> MemWrite drops to 0 same cycle; FETCH after.
//  - USE_READY=0, mem_ready tied 0 -> lw still completes in 5 cycles.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM: beq/j 3, R/I/sw 4, lw 5 cycles per instruction.
// Memory states stall on mem_ready low, holding strobes and address select stable.
module multicycle_control_fsm #(
  parameter int OPCODE_W  = 6,
  parameter int ALUOP_W   = 3,
  parameter bit USE_READY = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic                instr_done,
  output logic                illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_RTYPE_WB = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ITYPE_WB = 4'd5,
    S_MEMADR   = 4'd6,
    S_MEMRD    = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEMWR    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_source;
    logic               done;
    logic               illegal;
  } ctl_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b101);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  state_t             state, state_nxt;
  logic               ready;
  logic               op_r, op_i, op_lw, op_sw, op_beq, op_j, op_legal;
  logic [ALUOP_W-1:0] i_alu, i_alu_q;
  logic               is_lw_q;
  ctl_t               ctl;

  assign ready = USE_READY ? mem_ready : 1'b1;

  always_comb begin
    op_r   = (opcode == OP_RTYPE);
    op_lw  = (opcode == OP_LW);
    op_sw  = (opcode == OP_SW);
    op_beq = (opcode == OP_BEQ);
    op_j   = (opcode == OP_J);
    op_i   = 1'b1;
    i_alu  = ALU_ADD;
    case (opcode)
      OP_ADDI: i_alu = ALU_ADD;
      OP_ORI:  i_alu = ALU_OR;
      OP_ANDI: i_alu = ALU_AND;
      OP_SLTI: i_alu = ALU_SLT;
      default: op_i = 1'b0;
    endcase
    op_legal = op_r | op_i | op_lw | op_sw | op_beq | op_j;
  end

  // Opcode-dependent choices are captured in DECODE so later states need not trust the IR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      i_alu_q <= ALU_ADD;
      is_lw_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        i_alu_q <= i_alu;
        is_lw_q <= op_lw;
      end
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op_r)                state_nxt = S_EXEC_R;
        else if (op_i)           state_nxt = S_EXEC_I;
        else if (op_lw || op_sw) state_nxt = S_MEMADR;
        else if (op_beq)         state_nxt = S_BRANCH;
        else if (op_j)           state_nxt = S_JUMP;
        else                     state_nxt = S_FETCH;
      end
      S_EXEC_R: state_nxt = S_RTYPE_WB;
      S_EXEC_I: state_nxt = S_ITYPE_WB;
      S_MEMADR: state_nxt = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = ready ? S_MEM_WB : S_MEMRD;
      S_MEMWR:  state_nxt = ready ? S_FETCH : S_MEMWR;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = ready;
        ctl.pc_write  = ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        ctl.illegal   = ~op_legal;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.done      = 1'b1;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.alu_op    = i_alu_q;
      end
      S_ITYPE_WB: begin
        ctl.reg_write = 1'b1;
        ctl.done      = 1'b1;
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.done       = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        ctl.done      = ready;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        ctl.done          = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b10;
        ctl.done      = 1'b1;
      end
      default: ;
    endcase
    if (reset) ctl = '0;
  end

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign IRWrite     = ctl.ir_write;
  assign MemToReg    = ctl.mem_to_reg;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign ALUOp       = ctl.alu_op;
  assign PCSource    = ctl.pc_source;
  assign instr_done  = ctl.done;
  assign illegal_op  = ctl.illegal;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed table-driven bench for multicycle_control_fsm, plus a USE_READY=0 instance.
module tb_multicycle_control_fsm;

  // Field order: pcw pcwc iord mrd mwr irw m2r rdst rw srca | srcb | aluop | pcsrc | done ill
  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       done, ill;
  } ctl_t;

  localparam ctl_t E_RST  = 19'b0000000000_00_000_00_0_0;
  localparam ctl_t E_F    = 19'b1001010000_01_000_00_0_0;
  localparam ctl_t E_FS   = 19'b0001000000_01_000_00_0_0;
  localparam ctl_t E_D    = 19'b0000000000_11_000_00_0_0;
  localparam ctl_t E_DI   = 19'b0000000000_11_000_00_0_1;
  localparam ctl_t E_XR   = 19'b0000000001_00_010_00_0_0;
  localparam ctl_t E_RWB  = 19'b0000000110_00_000_00_1_0;
  localparam ctl_t E_XIA  = 19'b0000000001_10_000_00_0_0;
  localparam ctl_t E_XIO  = 19'b0000000001_10_011_00_0_0;
  localparam ctl_t E_IWB  = 19'b0000000010_00_000_00_1_0;
  localparam ctl_t E_MR   = 19'b0011000000_00_000_00_0_0;
  localparam ctl_t E_MWB  = 19'b0000001010_00_000_00_1_0;
  localparam ctl_t E_MW   = 19'b0010100000_00_000_00_1_0;
  localparam ctl_t E_MWS  = 19'b0010100000_00_000_00_0_0;
  localparam ctl_t E_BR   = 19'b0100000001_00_001_01_1_0;
  localparam ctl_t E_J    = 19'b1000000000_00_000_10_1_0;
  // Masks select the fields each state defines; write enables and pulses are always checked.
  localparam ctl_t M_ALL  = 19'b1111111111_11_111_11_1_1;
  localparam ctl_t M_F    = 19'b1111110011_11_111_11_1_1;
  localparam ctl_t M_D    = 19'b1101110011_11_111_00_1_1;
  localparam ctl_t M_WB   = 19'b1101111110_00_000_00_1_1;
  localparam ctl_t M_M    = 19'b1111110010_00_000_00_1_1;
  localparam ctl_t M_BR   = 19'b1101110011_11_111_11_1_1;
  localparam ctl_t M_J    = 19'b1101110010_00_000_11_1_1;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    ctl_t       exp;
    ctl_t       msk;
    string      nm;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       rst0 = 1'b1, zero0 = 1'b0, rdy0 = 1'b1;
  logic [5:0] op0 = 6'b0;
  logic       rst1 = 1'b1;
  logic [5:0] op1 = 6'b0;

  logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, done, ill;
  logic [1:0] srcb, pcsrc;
  logic [2:0] aluop;
  ctl_t       o0;

  logic       pcw_1, pcwc_1, iord_1, mrd_1, mwr_1, irw_1, m2r_1, rdst_1, rw_1, srca_1, done_1, ill_1;
  logic [1:0] srcb_1, pcsrc_1;
  logic [2:0] aluop_1;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.OPCODE_W(6), .ALUOP_W(3), .USE_READY(1'b1)) u0 (
    .clk(clk), .reset(rst0), .opcode(op0), .zero(zero0), .mem_ready(rdy0),
    .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
    .IRWrite(irw), .MemToReg(m2r), .RegDst(rdst), .RegWrite(rw), .ALUSrcA(srca),
    .ALUSrcB(srcb), .ALUOp(aluop), .PCSource(pcsrc), .instr_done(done), .illegal_op(ill)
  );

  multicycle_control_fsm #(.OPCODE_W(6), .ALUOP_W(3), .USE_READY(1'b0)) u1 (
    .clk(clk), .reset(rst1), .opcode(op1), .zero(1'b0), .mem_ready(1'b0),
    .PCWrite(pcw_1), .PCWriteCond(pcwc_1), .IorD(iord_1), .MemRead(mrd_1), .MemWrite(mwr_1),
    .IRWrite(irw_1), .MemToReg(m2r_1), .RegDst(rdst_1), .RegWrite(rw_1), .ALUSrcA(srca_1),
    .ALUSrcB(srcb_1), .ALUOp(aluop_1), .PCSource(pcsrc_1), .instr_done(done_1), .illegal_op(ill_1)
  );

  assign o0 = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, done, ill};

  task automatic add(input logic r, input logic [5:0] o, input logic z, input logic rd,
                     input ctl_t e, input ctl_t m, input string n);
    vec_t v;
    v.rst = r; v.op = o; v.z = z; v.rdy = rd; v.exp = e; v.msk = m; v.nm = n;
    tbl.push_back(v);
  endtask

  task automatic chk(input string n, input ctl_t a, input ctl_t e, input ctl_t m);
    checks++;
    if (((a ^ e) & m) != '0) begin
      errors++;
      $display("FAIL %s: got %b want %b mask %b", n, a, e, m);
    end
  endtask

  task automatic chk1(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  initial begin
    int n_done;
    bit found;

    add(1, 6'b000000, 0, 1, E_RST, M_ALL, "reset_c0");
    add(1, 6'b000000, 0, 1, E_RST, M_ALL, "reset_c1");
    add(0, 6'b000000, 0, 1, E_F,   M_F,   "r_fetch");
    add(0, 6'b000000, 0, 1, E_D,   M_D,   "r_decode");
    add(0, 6'b000000, 0, 1, E_XR,  M_D,   "r_exec");
    add(0, 6'b000000, 0, 1, E_RWB, M_WB,  "r_wb_done4");
    add(0, 6'b001000, 0, 1, E_F,   M_F,   "addi_fetch");
    add(0, 6'b001000, 0, 1, E_D,   M_D,   "addi_decode");
    add(0, 6'b001000, 0, 1, E_XIA, M_D,   "addi_exec");
    add(0, 6'b001000, 0, 1, E_IWB, M_WB,  "addi_wb_done4");
    add(0, 6'b100011, 0, 1, E_F,   M_F,   "lw_fetch");
    add(0, 6'b100011, 0, 1, E_D,   M_D,   "lw_decode");
    add(0, 6'b100011, 0, 1, E_XIA, M_D,   "lw_memadr");
    add(0, 6'b100011, 0, 1, E_MR,  M_M,   "lw_memrd");
    add(0, 6'b100011, 0, 1, E_MWB, M_WB,  "lw_wb_done5");
    add(0, 6'b101011, 0, 1, E_F,   M_F,   "sw_fetch");
    add(0, 6'b101011, 0, 1, E_D,   M_D,   "sw_decode");
    add(0, 6'b101011, 0, 1, E_XIA, M_D,   "sw_memadr");
    add(0, 6'b101011, 0, 1, E_MW,  M_M,   "sw_memwr_done4");
    add(0, 6'b000100, 1, 1, E_F,   M_F,   "beq1_fetch");
    add(0, 6'b000100, 1, 1, E_D,   M_D,   "beq1_decode");
    add(0, 6'b000100, 1, 1, E_BR,  M_BR,  "beq1_branch_done3");
    add(0, 6'b000010, 0, 1, E_F,   M_F,   "j_fetch");
    add(0, 6'b000010, 0, 1, E_D,   M_D,   "j_decode");
    add(0, 6'b000010, 0, 1, E_J,   M_J,   "j_jump_done3");
    add(0, 6'b000100, 0, 1, E_F,   M_F,   "beq0_fetch");
    add(0, 6'b000100, 0, 1, E_D,   M_D,   "beq0_decode");
    add(0, 6'b000100, 0, 1, E_BR,  M_BR,  "beq0_branch_done3");
    add(0, 6'b001101, 0, 1, E_F,   M_F,   "ori_fetch");
    add(0, 6'b001101, 0, 1, E_D,   M_D,   "ori_decode");
    add(0, 6'b001101, 0, 1, E_XIO, M_D,   "ori_exec_aluop_or");
    add(0, 6'b001101, 0, 1, E_IWB, M_WB,  "ori_wb");
    add(0, 6'b111111, 0, 1, E_F,   M_F,   "ill_fetch");
    add(0, 6'b111111, 0, 1, E_DI,  M_D,   "ill_decode_pulse");
    // Stalled lw: 3 fetch stalls + 2 MEMRD stalls stretch it to 10 cycles.
    add(0, 6'b100011, 0, 0, E_FS,  M_F,   "lws_fetch_stall1");
    add(0, 6'b100011, 0, 0, E_FS,  M_F,   "lws_fetch_stall2");
    add(0, 6'b100011, 0, 0, E_FS,  M_F,   "lws_fetch_stall3");
    add(0, 6'b100011, 0, 1, E_F,   M_F,   "lws_fetch_go");
    add(0, 6'b100011, 0, 1, E_D,   M_D,   "lws_decode");
    add(0, 6'b100011, 0, 1, E_XIA, M_D,   "lws_memadr");
    add(0, 6'b100011, 0, 0, E_MR,  M_M,   "lws_memrd_stall1");
    add(0, 6'b100011, 0, 0, E_MR,  M_M,   "lws_memrd_stall2");
    add(0, 6'b100011, 0, 1, E_MR,  M_M,   "lws_memrd_go");
    add(0, 6'b100011, 0, 1, E_MWB, M_WB,  "lws_wb_done10");
    // sw aborted by reset while stalled in MEMWR.
    add(0, 6'b101011, 0, 1, E_F,   M_F,   "swr_fetch");
    add(0, 6'b101011, 0, 1, E_D,   M_D,   "swr_decode");
    add(0, 6'b101011, 0, 1, E_XIA, M_D,   "swr_memadr");
    add(0, 6'b101011, 0, 0, E_MWS, M_M,   "swr_memwr_stall");
    add(1, 6'b101011, 0, 0, E_RST, M_ALL, "swr_reset_drops_memwrite");
    add(0, 6'b101011, 0, 1, E_F,   M_F,   "swr_fetch_after_reset");

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst0 = tbl[i].rst; op0 = tbl[i].op; zero0 = tbl[i].z; rdy0 = tbl[i].rdy;
      #3;
      chk(tbl[i].nm, o0, tbl[i].exp, tbl[i].msk);
    end

    // USE_READY=0 with mem_ready tied low: lw must still finish in 5 cycles.
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    op1  = 6'b100011;
    n_done = 0;
    found  = 1'b0;
    for (int c = 1; c <= 20 && !found; c++) begin
      #3;
      if (c == 1) chk1("nr_fetch_irwrite", int'(irw_1), 1);
      if (done_1) begin
        found  = 1'b1;
        n_done = c;
        chk1("nr_wb_regwrite", int'(rw_1), 1);
        chk1("nr_wb_memtoreg", int'(m2r_1), 1);
      end
      @(posedge clk);
      #1;
    end
    chk1("nr_lw_latency", n_done, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
